mac_sequencer: RTL and testbench

Sequencer for the MAC operand memory. On `start` it walks a run of operand pairs (8 bytes each: first operand at `A`, second at `A+4`, big-endian), holds `stop_signal` high while addressing each pair, registers both 32-bit operands, and accumulates their signed products. It sits between the core's MAC issue logic and the operand memory. It owns the memory's `address`/`stop_signal` inputs and returns one accumulated result per run.

---
 rtl/mac_sequencer_if.sv | 31 +++
 rtl/mac_sequencer.sv | 145 ++++++++++++++
 tb/tb_mac_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_sequencer_if.sv
// Signal bundle between mac_sequencer, the MAC issue logic and the operand memory.
// master = sequencer side, slave = issue logic / memory side.
interface mac_sequencer_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int CNT_W  = 5
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  pair_count;
    logic [DATA_W-1:0] first_operand;
    logic [DATA_W-1:0] second_operand;
    logic [ADDR_W-1:0] address;
    logic              stop_signal;
    logic              busy;
    logic              done;
    logic              err;
    logic              overflow;
    logic [ACC_W-1:0]  acc_out;

    modport master (
        input  start, base_addr, pair_count, first_operand, second_operand,
        output address, stop_signal, busy, done, err, overflow, acc_out
    );

    modport slave (
        output start, base_addr, pair_count, first_operand, second_operand,
        input  address, stop_signal, busy, done, err, overflow, acc_out
    );
endinterface

// File: rtl/mac_sequencer.sv
// Walks a run of big-endian operand pairs in the operand memory and accumulates their signed products.
// Optional feature macro: MAC_SATURATE_EN (clamp the accumulator on overflow instead of wrapping).
module mac_sequencer #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int CNT_W  = 5
) (
    input  logic            clk,
    input  logic            reset,
    mac_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_MAC,
        S_DONE
    } state_t;

    localparam int RW = (CNT_W + 4 > 9) ? CNT_W + 4 : 9;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [ADDR_W-1:0]        r_ptr;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [DATA_W-1:0] r_op1_p0;
    logic signed [DATA_W-1:0] r_op2_p0;
    logic signed [ACC_W-1:0]  r_acc_p1;
    logic [ACC_W-1:0]         r_acc_out;
    logic                     r_ovf;
    logic                     r_err;

    logic [RW-1:0]              w_end;
    logic                       w_legal;
    logic                       w_accept;
    logic signed [2*DATA_W-1:0] w_op1_ext;
    logic signed [2*DATA_W-1:0] w_op2_ext;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W:0]      w_sum;
    logic                       w_sum_ovf;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic                       w_last;

    function automatic logic signed [ACC_W-1:0] resolve_ovf(input logic signed [ACC_W:0] s);
`ifdef MAC_SATURATE_EN
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
`else
        return s[ACC_W-1:0];
`endif
    endfunction

    // Window check: aligned pair and the whole run stays inside one 128-byte window
    assign w_end    = RW'(bus.base_addr[6:0]) + RW'({bus.pair_count, 3'b000});
    assign w_legal  = (bus.base_addr[2:0] == 3'b000) && (w_end <= RW'(128));
    assign w_accept = (r_state == S_IDLE) && bus.start && w_legal;
    assign w_last   = (r_cnt == CNT_W'(1));

    assign w_op1_ext  = (2*DATA_W)'(r_op1_p0);
    assign w_op2_ext  = (2*DATA_W)'(r_op2_p0);
    assign w_prod     = w_op1_ext * w_op2_ext;
    assign w_sum      = (ACC_W+1)'(r_acc_p1) + (ACC_W+1)'(w_prod);
    assign w_sum_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign w_acc_next = resolve_ovf(w_sum);

    always_comb begin
        w_state_next    = r_state;
        bus.stop_signal = 1'b0;
        bus.address     = '1;
        bus.busy        = 1'b1;
        bus.done        = 1'b0;
        bus.err         = r_err;
        bus.overflow    = r_ovf;
        bus.acc_out     = r_acc_out;
        case (r_state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (w_accept)
                    w_state_next = (bus.pair_count == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                bus.stop_signal = 1'b1;
                bus.address     = r_ptr;
                w_state_next    = S_CAPTURE;
            end
            S_CAPTURE: begin
                bus.stop_signal = 1'b1;
                bus.address     = r_ptr;
                w_state_next    = S_MAC;
            end
            S_MAC: begin
                w_state_next = w_last ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                bus.done     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_err     <= 1'b0;
            r_ovf     <= 1'b0;
            r_acc_out <= '0;
        end else begin
            r_state <= w_state_next;
            r_err   <= (r_state == S_IDLE) && bus.start && !w_legal;
            if (w_accept) begin
                r_ovf <= 1'b0;
                if (bus.pair_count == '0)
                    r_acc_out <= '0;
            end else if (r_state == S_MAC) begin
                if (w_sum_ovf)
                    r_ovf <= 1'b1;
                if (w_last)
                    r_acc_out <= w_acc_next;
            end
        end
    end

    // Stage p0: operand capture at the end of CAPTURE; stage p1: accumulate in MAC
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_acc_p1 <= '0;
            r_ptr    <= bus.base_addr;
            r_cnt    <= bus.pair_count;
        end
        if (r_state == S_CAPTURE) begin
            r_op1_p0 <= bus.first_operand;
            r_op2_p0 <= bus.second_operand;
        end
        if (r_state == S_MAC) begin
            r_acc_p1 <= w_acc_next;
            r_ptr    <= r_ptr + ADDR_W'(8);
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mac_sequencer.sv
// Randomized self-checking bench for mac_sequencer against a run-level reference model.
module tb_mac_sequencer;
    logic clk;
    logic reset;

    mac_sequencer_if #(.ADDR_W(21), .DATA_W(32), .ACC_W(64), .CNT_W(5)) bus ();

    mac_sequencer #(.ADDR_W(21), .DATA_W(32), .ACC_W(64), .CNT_W(5)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] mem [4096];
    logic [63:0] last_acc = '0;
    logic        last_ovf = 1'b0;
    logic signed [127:0] c_max;
    logic signed [127:0] c_min;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_word(input int a);
        return {mem[a & 4095], mem[(a + 1) & 4095], mem[(a + 2) & 4095], mem[(a + 3) & 4095]};
    endfunction

    always_comb begin
        bus.first_operand  = rd_word(int'(bus.address[11:0]));
        bus.second_operand = rd_word(int'(bus.address[11:0]) + 4);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic put_pair(input int a, input logic [31:0] w1, input logic [31:0] w2);
        for (int i = 0; i < 4; i++) begin
            mem[(a + i) & 4095]     = w1[31-8*i -: 8];
            mem[(a + 4 + i) & 4095] = w2[31-8*i -: 8];
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, 64'(bus.address), 64'(21'h1FFFFF));
        chk({tag, "_stop"}, 64'(bus.stop_signal), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_err"},  64'(bus.err), 64'd0);
        chk({tag, "_ovf"},  64'(bus.overflow), 64'd0);
        chk({tag, "_acc"},  bus.acc_out, 64'd0);
    endtask

    // Called and returns just after a rising edge.
    task automatic run_seq(input logic [20:0] base, input int cnt, input bit poke_busy, input int rst_cyc);
        bit                  legal;
        int                  n_done;
        int                  k;
        int                  ph;
        bit                  st;
        int                  w1;
        int                  w2;
        longint              p;
        longint              acc_m;
        bit                  ovf_m;
        logic signed [127:0] t;
        logic [20:0]         exp_addr;

        legal = (base[2:0] == 3'b000) && (int'(base[6:0]) + 8 * cnt <= 128);
        acc_m = 0;
        ovf_m = 1'b0;
        for (int j = 0; j < cnt; j++) begin
            w1 = int'(rd_word(int'(base[11:0]) + 8 * j));
            w2 = int'(rd_word(int'(base[11:0]) + 8 * j + 4));
            p  = longint'(w1) * longint'(w2);
            t  = 128'(acc_m) + 128'(p);
            if (t > c_max || t < c_min) begin
                ovf_m = 1'b1;
`ifdef MAC_SATURATE_EN
                acc_m = (t > c_max) ? longint'(c_max[63:0]) : longint'(c_min[63:0]);
`else
                acc_m = longint'(t[63:0]);
`endif
            end else begin
                acc_m = longint'(t[63:0]);
            end
        end

        bus.base_addr  = base;
        bus.pair_count = 5'(cnt);
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;

        if (!legal) begin
            chk("rej_err",  64'(bus.err), 64'd1);
            chk("rej_busy", 64'(bus.busy), 64'd0);
            chk("rej_done", 64'(bus.done), 64'd0);
            chk("rej_stop", 64'(bus.stop_signal), 64'd0);
            chk("rej_acc",  bus.acc_out, last_acc);
            chk("rej_ovf",  64'(bus.overflow), 64'(last_ovf));
            @(posedge clk); #1;
            chk("rej_err_clr", 64'(bus.err), 64'd0);
            return;
        end

        n_done = 3 * cnt + 1;
        for (int cyc = 1; cyc <= n_done + 1; cyc++) begin
            if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
                chk_reset_vals("rst_mid");
                reset    = 1'b1;
                last_acc = '0;
                last_ovf = 1'b0;
                @(posedge clk); #1;
                return;
            end
            k        = (cyc - 1) / 3;
            ph       = (cyc - 1) % 3;
            st       = (cyc < n_done) && (ph != 2);
            exp_addr = st ? 21'(base + 21'(8 * k)) : '1;
            chk("stop", 64'(bus.stop_signal), 64'(st));
            chk("addr", 64'(bus.address), 64'(exp_addr));
            chk("busy", 64'(bus.busy), 64'(cyc <= n_done));
            chk("done", 64'(bus.done), 64'(cyc == n_done));
            chk("err",  64'(bus.err), 64'd0);
            if (cyc == n_done) begin
                chk("acc", bus.acc_out, 64'(acc_m));
                chk("ovf", 64'(bus.overflow), 64'(ovf_m));
                last_acc = 64'(acc_m);
                last_ovf = ovf_m;
            end
            if (poke_busy && cyc == 2) begin
                bus.base_addr  = 21'($urandom_range(0, 4095));
                bus.pair_count = 5'($urandom_range(0, 16));
                bus.start      = 1'b1;
            end
            if (poke_busy && cyc == 3)
                bus.start = 1'b0;
            if (rst_cyc > 0 && cyc == rst_cyc)
                reset = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [20:0] rb;
        int          rc;
        c_max = 128'(64'sh7FFF_FFFF_FFFF_FFFF);
        c_min = -c_max - 128'sd1;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.pair_count = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");
        reset = 1'b1;
        @(posedge clk); #1;

        put_pair(0, 32'd3, 32'd4);
        run_seq(21'd0, 1, 1'b0, 0);
        chk("single_acc", bus.acc_out, 64'd12);

        put_pair(16, 32'd2, 32'd5);
        put_pair(24, 32'hFFFF_FFFF, 32'd7);
        put_pair(32, 32'd10, 32'd10);
        run_seq(21'd16, 3, 1'b0, 0);
        chk("multi_acc", bus.acc_out, 64'd103);

        run_seq(21'd120, 2, 1'b0, 0);
        run_seq(21'd4, 1, 1'b0, 0);
        put_pair(120, 32'hFFFF_FFFE, 32'd9);
        run_seq(21'd120, 1, 1'b0, 0);
        chk("edge_acc", bus.acc_out, 64'hFFFF_FFFF_FFFF_FFEE);

        run_seq(21'd64, 0, 1'b0, 0);
        chk("zero_acc", bus.acc_out, 64'd0);

        run_seq(21'd16, 3, 1'b1, 0);
        chk("poke_acc", bus.acc_out, 64'd103);

        put_pair(0, 32'h8000_0000, 32'h8000_0000);
        put_pair(8, 32'h8000_0000, 32'h8000_0000);
        run_seq(21'd0, 2, 1'b0, 0);
`ifdef MAC_SATURATE_EN
        chk("ovf_acc", bus.acc_out, 64'h7FFF_FFFF_FFFF_FFFF);
`else
        chk("ovf_acc", bus.acc_out, 64'h8000_0000_0000_0000);
`endif
        chk("ovf_flag", 64'(bus.overflow), 64'd1);

        run_seq(21'd16, 3, 1'b0, 5);
        run_seq(21'd16, 3, 1'b0, 0);
        chk("after_rst_acc", bus.acc_out, 64'd103);

        for (int r = 0; r < 60; r++) begin
            rb = 21'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) rb[2:0] = 3'b000;
            rc = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16);
            for (int j = 0; j < 2 * rc; j++) begin
                case ($urandom_range(0, 5))
                    0:       put_word(int'(rb[11:0]) + 4 * j, 32'h8000_0000);
                    1:       put_word(int'(rb[11:0]) + 4 * j, 32'h7FFF_FFFF);
                    default: put_word(int'(rb[11:0]) + 4 * j, $urandom);
                endcase
            end
            run_seq(rb, rc, ($urandom_range(0, 4) == 0), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    task automatic put_word(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[(a + i) & 4095] = w[31-8*i -: 8];
    endtask
endmodule
